// File: rtl/conv_buf_pkg.sv
// Shared defaults and helpers for the ping-pong convolution frame buffer.
// Bank-state encoding describes the two full flags as one 2-bit word.
package conv_buf_pkg;

  localparam int CFB_IMG_W = 28;
  localparam int CFB_IMG_H = 28;
  localparam int CFB_K     = 5;
  localparam int CFB_PIX_W = 1;

  // Bit b set means bank b holds a complete frame.
  typedef enum logic [1:0] {
    BANKS_EMPTY = 2'b00,
    BANK0_FULL  = 2'b01,
    BANK1_FULL  = 2'b10,
    BANKS_FULL  = 2'b11
  } bank_state_e;

  // Index width for a dimension; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fbuf_row_ram.sv
// One image row for both banks: synchronous write, registered read.
// Logical address is {bank, col}; bank 1 is stored after the IMG_W entries of bank 0.
module fbuf_row_ram
  import conv_buf_pkg::*;
#(
  parameter int COLS  = CFB_IMG_W,
  parameter int PIX_W = CFB_PIX_W,
  parameter int CW    = idx_w(COLS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CW:0]      waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [CW:0]      raddr,
  output logic [PIX_W-1:0] rdata
);

  localparam int DEPTH = 2 * COLS;
  localparam int AW    = idx_w(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rdata_q;
  logic [AW-1:0]    widx_s;
  logic [AW-1:0]    ridx_s;
  logic             rd_ok_s;

  function automatic logic [AW-1:0] lin_idx(input logic [CW:0] a);
    logic [AW-1:0] base;
    if (a[CW]) begin
      base = AW'(COLS);
    end else begin
      base = '0;
    end
    return base + AW'(a[CW-1:0]);
  endfunction

  always_comb begin
    widx_s  = lin_idx(waddr);
    ridx_s  = lin_idx(raddr);
    // Columns beyond the image would index past the array; the top masks them anyway.
    rd_ok_s = (int'(raddr[CW-1:0]) < COLS);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx_s] <= wdata;
    end
    if (rd_ok_s) begin
      rdata_q <= mem[ridx_s];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_frame_buf.sv
// Ping-pong frame buffer: raster writes into one bank while the conv side
// reads K-row vertical window slices from the other.
module conv_frame_buf
  import conv_buf_pkg::*;
#(
  parameter int IMG_W = CFB_IMG_W,
  parameter int IMG_H = CFB_IMG_H,
  parameter int K     = CFB_K,
  parameter int PIX_W = CFB_PIX_W,
  parameter int CW    = idx_w(IMG_W),
  parameter int RW    = idx_w(IMG_H)
) (
  input  logic               sclk,
  input  logic               s_rst,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_vld,
  input  logic               in_sof,
  output logic               in_rdy,
  input  logic               rd_en,
  input  logic [CW-1:0]      rd_col,
  input  logic [RW-1:0]      rd_row,
  input  logic               rd_done,
  output logic               frm_start,
  output logic               rd_own,
  output logic [K*PIX_W-1:0] win_data,
  output logic               win_vld
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'((IMG_W > 1) ? 1 : 0);

  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic          rd_bank_q, rd_bank_d;
  logic          rd_own_q, rd_own_d;
  logic          frm_start_q, frm_start_d;
  logic          in_rdy_q, in_rdy_d;
  logic          win_vld_q, win_vld_d;
  logic          win_oob_q, win_oob_d;
  logic [RW-1:0] win_row_q, win_row_d;

  logic               beat_s;
  logic               last_s;
  logic               release_s;
  logic [CW-1:0]      pos_col_s;
  logic [RW-1:0]      pos_row_s;
  logic [IMG_H-1:0]   we_s;
  logic [CW:0]        waddr_s;
  logic [CW:0]        raddr_s;
  logic [PIX_W-1:0]   row_rd_s [IMG_H];
  logic [K*PIX_W-1:0] win_data_s;

  // Position of the beat being accepted; a start-of-frame beat always lands at (0,0).
  always_comb begin
    beat_s = in_vld && in_rdy_q;
    if (in_sof) begin
      pos_col_s = '0;
      pos_row_s = '0;
    end else begin
      pos_col_s = wr_col_q;
      pos_row_s = wr_row_q;
    end
    last_s  = beat_s && (pos_col_s == COL_LAST) && (pos_row_s == ROW_LAST);
    waddr_s = {wr_bank_q, pos_col_s};
    raddr_s = {rd_bank_q, rd_col};
    we_s    = '0;
    for (int r = 0; r < IMG_H; r++) begin
      we_s[r] = beat_s && (int'(pos_row_s) == r);
    end
  end

  always_comb begin
    wr_col_d  = wr_col_q;
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    if (last_s) begin
      wr_col_d  = '0;
      wr_row_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (beat_s) begin
      if (pos_col_s == COL_LAST) begin
        wr_col_d = '0;
        wr_row_d = pos_row_s + RW'(1);
      end else begin
        wr_col_d = (pos_col_s == '0 && in_sof) ? COL_ONE : pos_col_s + CW'(1);
        wr_row_d = pos_row_s;
      end
    end else begin
      wr_col_d = wr_col_q;
    end
  end

  // Release and handover are exclusive per cycle, so a freed bank is handed over one cycle later.
  always_comb begin
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    rd_own_d    = rd_own_q;
    frm_start_d = 1'b0;
    release_s   = rd_done && rd_own_q;
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      rd_own_d          = 1'b0;
    end else if (!rd_own_q && full_q[rd_bank_q]) begin
      rd_own_d    = 1'b1;
      frm_start_d = 1'b1;
    end else begin
      rd_own_d = rd_own_q;
    end
    if (last_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_d[wr_bank_q];
    end
    in_rdy_d = !full_d[wr_bank_d];
  end

  always_comb begin
    win_vld_d = rd_en && rd_own_q;
    win_oob_d = (int'(rd_col) >= IMG_W) || (int'(rd_row) > (IMG_H - K));
    win_row_d = rd_row;
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= BANKS_EMPTY;
      rd_bank_q   <= 1'b0;
      rd_own_q    <= 1'b0;
      frm_start_q <= 1'b0;
      in_rdy_q    <= 1'b1;
      win_vld_q   <= 1'b0;
      win_oob_q   <= 1'b0;
      win_row_q   <= '0;
    end else begin
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      rd_own_q    <= rd_own_d;
      frm_start_q <= frm_start_d;
      in_rdy_q    <= in_rdy_d;
      win_vld_q   <= win_vld_d;
      win_oob_q   <= win_oob_d;
      win_row_q   <= win_row_d;
    end
  end

  for (genvar r = 0; r < IMG_H; r++) begin : g_row
    fbuf_row_ram #(
      .COLS  (IMG_W),
      .PIX_W (PIX_W),
      .CW    (CW)
    ) u_ram (
      .clk   (sclk),
      .we    (we_s[r]),
      .waddr (waddr_s),
      .wdata (in_data),
      .raddr (raddr_s),
      .rdata (row_rd_s[r])
    );
  end

  // K-row select from the registered row reads; row win_row_q goes to the LSB slice.
  always_comb begin
    win_data_s = '0;
    if (win_vld_q && !win_oob_q) begin
      for (int k = 0; k < K; k++) begin
        if ((int'(win_row_q) + k) < IMG_H) begin
          win_data_s[k*PIX_W +: PIX_W] = row_rd_s[win_row_q + RW'(k)];
        end else begin
          win_data_s[k*PIX_W +: PIX_W] = '0;
        end
      end
    end else begin
      win_data_s = '0;
    end
  end

  assign in_rdy    = in_rdy_q;
  assign frm_start = frm_start_q;
  assign rd_own    = rd_own_q;
  assign win_vld   = win_vld_q;
  assign win_data  = win_data_s;

endmodule

// File: tb/tb_conv_frame_buf.sv
// Directed bench for conv_frame_buf: default 28x28x1 K=5 instance plus a 16x16x8 K=3 instance.
module tb_conv_frame_buf;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic [0:0]  in_data;
  logic        in_vld, in_sof, in_rdy;
  logic        rd_en, rd_done, frm_start, rd_own, win_vld;
  logic [4:0]  rd_col, rd_row;
  logic [4:0]  win_data;

  logic [7:0]  in_data8;
  logic        in_vld8, in_sof8, in_rdy8;
  logic        rd_en8, rd_done8, frm_start8, rd_own8, win_vld8;
  logic [3:0]  rd_col8, rd_row8;
  logic [23:0] win_data8;

  int tests = 0;
  int fails = 0;

  always #5 sclk = ~sclk;

  conv_frame_buf dut (
    .sclk(sclk), .s_rst(s_rst), .in_data(in_data), .in_vld(in_vld), .in_sof(in_sof),
    .in_rdy(in_rdy), .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row), .rd_done(rd_done),
    .frm_start(frm_start), .rd_own(rd_own), .win_data(win_data), .win_vld(win_vld)
  );

  conv_frame_buf #(.IMG_W(16), .IMG_H(16), .K(3), .PIX_W(8)) dut8 (
    .sclk(sclk), .s_rst(s_rst), .in_data(in_data8), .in_vld(in_vld8), .in_sof(in_sof8),
    .in_rdy(in_rdy8), .rd_en(rd_en8), .rd_col(rd_col8), .rd_row(rd_row8), .rd_done(rd_done8),
    .frm_start(frm_start8), .rd_own(rd_own8), .win_data(win_data8), .win_vld(win_vld8)
  );

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pix(input int p, input int r, input int c);
    case (p)
      0:       return ((r + c) % 2) == 1;
      1:       return ((r / 3 + c) % 2) == 1;
      default: return ((r * c) % 3) == 0;
    endcase
  endfunction

  function automatic logic [4:0] exp_win(input int p, input int row, input int col);
    logic [4:0] e;
    for (int k = 0; k < 5; k++) e[k] = pix(p, row + k, col);
    return e;
  endfunction

  task automatic wait_rdy(inout int stalls);
    int n = 0;
    while (!in_rdy && n < 2000) begin
      tick;
      n++;
      stalls++;
    end
    if (n >= 2000) chk("rdy_timeout", 32'(in_rdy), 32'd1);
  endtask

  // Streams pixels of pattern p starting at raster index first; beat 'first' carries sof.
  task automatic send_pix(input int p, input int first, input int count, output int stalls);
    stalls = 0;
    for (int i = first; i < first + count; i++) begin
      in_data = pix(p, i / 28, i % 28);
      in_sof  = (i == first);
      in_vld  = 1'b1;
      wait_rdy(stalls);
      tick;
    end
    in_vld = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int col, input int row,
                          input logic ev, input logic [31:0] ed);
    rd_en  = 1'b1;
    rd_col = 5'(col);
    rd_row = 5'(row);
    tick;
    chk({tag, "_vld"}, 32'(win_vld), 32'(ev));
    chk({tag, "_data"}, 32'(win_data), ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int n;
    s_rst = 1'b1; in_data = '0; in_vld = 1'b0; in_sof = 1'b0;
    rd_en = 1'b0; rd_col = '0; rd_row = '0; rd_done = 1'b0;
    in_data8 = '0; in_vld8 = 1'b0; in_sof8 = 1'b0;
    rd_en8 = 1'b0; rd_col8 = '0; rd_row8 = '0; rd_done8 = 1'b0;
    repeat (3) tick;
    s_rst = 1'b0;

    // Reset state, stray rd_done and an unowned read.
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_rd_own", 32'(rd_own), 32'd0);
    chk("rst_frm_start", 32'(frm_start), 32'd0);
    chk("rst_win_vld", 32'(win_vld), 32'd0);
    chk("rst_win_data", 32'(win_data), 32'd0);
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    chk("stray_done_own", 32'(rd_own), 32'd0);
    read_chk("unowned", 3, 0, 1'b0, 32'd0);
    rd_en = 1'b0;

    // Frame 1: last beat in N, frm_start only in N+2, pulse lasts one cycle.
    send_pix(0, 0, 784, st);
    chk("f1_fs_n1", 32'(frm_start), 32'd0);
    tick;
    chk("f1_fs_n2", 32'(frm_start), 32'd1);
    chk("f1_own", 32'(rd_own), 32'd1);
    tick;
    chk("f1_fs_pulse", 32'(frm_start), 32'd0);
    read_chk("f1_c3r0", 3, 0, 1'b1, 32'd21);
    for (int c = 0; c < 28; c++) read_chk("f1_sweep", c, 2, 1'b1, 32'(exp_win(0, 2, c)));
    read_chk("f1_row23", 10, 23, 1'b1, 32'(exp_win(0, 23, 10)));
    read_chk("f1_row24", 0, 24, 1'b1, 32'd0);
    read_chk("f1_col28", 28, 0, 1'b1, 32'd0);
    read_chk("f1_col31", 31, 31, 1'b1, 32'd0);
    rd_en = 1'b0;

    // Frame 2 streams into the other bank while frame 1 is owned.
    send_pix(1, 0, 784, st);
    chk("f2_no_stall", 32'(st), 32'd0);
    chk("f2_own_kept", 32'(rd_own), 32'd1);
    chk("f2_no_fs", 32'(frm_start), 32'd0);
    chk("both_full_rdy", 32'(in_rdy), 32'd0);

    // Frame 3 beat 0 stalls; frame 1 stays readable meanwhile.
    in_data = pix(2, 0, 0);
    in_sof  = 1'b1;
    in_vld  = 1'b1;
    repeat (3) tick;
    chk("f3_stall", 32'(in_rdy), 32'd0);
    read_chk("f1_intact", 3, 0, 1'b1, 32'(exp_win(0, 0, 3)));
    rd_en  = 1'b0;
    in_vld = 1'b0;
    in_sof = 1'b0;

    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    chk("done_own_n1", 32'(rd_own), 32'd0);
    chk("done_fs_n1", 32'(frm_start), 32'd0);
    chk("done_rdy_n1", 32'(in_rdy), 32'd1);
    rd_en  = 1'b1;
    rd_col = 5'd0;
    rd_row = 5'd0;
    tick;
    rd_en = 1'b0;
    chk("done_fs_n2", 32'(frm_start), 32'd1);
    chk("done_own_n2", 32'(rd_own), 32'd1);
    chk("done_unowned_rd", 32'(win_vld), 32'd0);
    read_chk("f2_c5r7", 5, 7, 1'b1, 32'(exp_win(1, 7, 5)));
    read_chk("f2_c27r23", 27, 23, 1'b1, 32'(exp_win(1, 23, 27)));
    read_chk("f2_c0r0", 0, 0, 1'b1, 32'(exp_win(1, 0, 0)));
    rd_en = 1'b0;

    // Fill the freed bank, then reset with both banks full and a read pending.
    send_pix(2, 0, 784, st);
    chk("f3_both_full", 32'(in_rdy), 32'd0);
    s_rst  = 1'b1;
    rd_en  = 1'b1;
    rd_col = 5'd3;
    tick;
    s_rst = 1'b0;
    rd_en = 1'b0;
    chk("srst_own", 32'(rd_own), 32'd0);
    chk("srst_fs", 32'(frm_start), 32'd0);
    chk("srst_win_vld", 32'(win_vld), 32'd0);
    chk("srst_win_data", 32'(win_data), 32'd0);
    chk("srst_rdy", 32'(in_rdy), 32'd1);
    tick;
    chk("srst_no_handover", 32'(frm_start), 32'd0);

    // Partial frame up to (10,5), then sof restarts with a new pattern.
    send_pix(1, 0, 10 * 28 + 5, st);
    send_pix(2, 0, 784, st);
    chk("sof_fs_n1", 32'(frm_start), 32'd0);
    tick;
    chk("sof_fs_n2", 32'(frm_start), 32'd1);
    read_chk("sof_c5r6", 5, 6, 1'b1, 32'(exp_win(2, 6, 5)));
    read_chk("sof_c4r10", 4, 10, 1'b1, 32'(exp_win(2, 10, 4)));
    read_chk("sof_c1r0", 1, 0, 1'b1, 32'(exp_win(2, 0, 1)));
    read_chk("sof_c27r23", 27, 23, 1'b1, 32'(exp_win(2, 23, 27)));
    rd_en = 1'b0;

    // 16x16 8-bit instance: ramp frame row*16+col.
    for (int i = 0; i < 256; i++) begin
      in_data8 = 8'(i);
      in_sof8  = (i == 0);
      in_vld8  = 1'b1;
      n = 0;
      while (!in_rdy8 && n < 100) begin
        tick;
        n++;
      end
      tick;
    end
    in_vld8 = 1'b0;
    in_sof8 = 1'b0;
    n = 0;
    while (!frm_start8 && n < 10) begin
      tick;
      n++;
    end
    chk("p8_fs_seen", 32'(frm_start8), 32'd1);
    rd_en8  = 1'b1;
    rd_col8 = 4'd7;
    rd_row8 = 4'd4;
    tick;
    chk("p8_c7r4_vld", 32'(win_vld8), 32'd1);
    chk("p8_c7r4_data", 32'(win_data8), {8'd0, 8'd103, 8'd87, 8'd71});
    rd_col8 = 4'd15;
    rd_row8 = 4'd13;
    tick;
    chk("p8_c15r13_data", 32'(win_data8), {8'd0, 8'd255, 8'd239, 8'd223});
    rd_row8 = 4'd14;
    tick;
    chk("p8_r14_vld", 32'(win_vld8), 32'd1);
    chk("p8_r14_data", 32'(win_data8), 32'd0);
    rd_en8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
